// File: rtl/fighter_sprite_engine.sv
// Per-fighter sprite engine: animation sequencing, frame-locked motion and a two-stage
// pixel fetch pipeline driving one external sprite ROM.
module fighter_sprite_engine #(
    parameter int                          NUM_ANIM     = 6,
    parameter int                          ADDR_W       = 19,
    parameter int                          SCALE_SH     = 1,
    parameter logic [NUM_ANIM*8-1:0]       ANIM_W       = {8'd40, 8'd40, 8'd40, 8'd40, 8'd48, 8'd37},
    parameter logic [NUM_ANIM*8-1:0]       ANIM_H       = {8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60},
    parameter logic [NUM_ANIM*4-1:0]       ANIM_NF      = {4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2},
    parameter logic [NUM_ANIM*ADDR_W-1:0]  ANIM_BASE    = {19'd80000, 19'd60000, 19'd40000,
                                                           19'd20000, 19'd8896, 19'd256},
    parameter logic [NUM_ANIM-1:0]         ANIM_ONESHOT = 6'b111110,
    parameter int                          FRAME_HOLD   = 4,
    parameter int                          START_X      = 560,
    parameter int                          START_Y      = 200,
    parameter int                          X_MIN        = 0,
    parameter int                          X_MAX        = 560,
    parameter int                          STEP         = 1,
    parameter int                          KNOCKBACK    = 40,
    parameter int                          MIN_GAP      = 50,
    parameter logic [7:0]                  TRANSPARENT  = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [2:0]        anim_req,
    input  logic              anim_req_vld,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              face_left,
    input  logic [9:0]        opp_x,
    input  logic              opp_solid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              is_sprite,
    output logic [7:0]        pix_index,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic [2:0]        anim_cur,
    output logic [3:0]        frame_num,
    output logic              anim_done
);

    localparam int                 HOLD_W      = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [2:0]         HURT_IDX    = 3'd5;
    localparam logic [7:0]         ONESHOT_PAD = 8'(ANIM_ONESHOT);
    localparam logic signed [11:0] STEP_S      = 12'(STEP);
    localparam logic signed [11:0] KB_S        = 12'(KNOCKBACK);
    localparam logic signed [11:0] GAP_S       = 12'(MIN_GAP);
    localparam logic signed [11:0] XMIN_S      = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S      = 12'(X_MAX);

    typedef enum logic {ST_IDLE_LOOP = 1'b0, ST_ONESHOT = 1'b1} anim_state_t;

    anim_state_t       state_r, state_nx_s;
    logic [2:0]        fclk_sync_r;
    logic [2:0]        anim_cur_r, anim_nx_s;
    logic [3:0]        frame_num_r, frame_nx_s;
    logic [HOLD_W-1:0] hold_r, hold_nx_s;
    logic [9:0]        pos_x_r, pos_y_r;
    logic              anim_done_r, done_s;
    logic              tick_s, req_ok_s, req_os_s, accept_s;
    logic [7:0]        w_cur_s, h_cur_s;
    logic [3:0]        nf_cur_s;
    logic signed [11:0] x_walk_s, x_gap_s, x_new_s, opp_s, diff_s;
    logic signed [11:0] dx_s, dy_s;
    logic [11:0]       w_span_s, h_span_s;
    logic [7:0]        col_s, col_m_s, row_s;
    logic              hit_s, hit_d1_r, is_sprite_r;
    logic [ADDR_W-1:0] addr_s, rom_addr_r;
    logic [7:0]        pix_index_r;

    assign tick_s   = fclk_sync_r[1] & ~fclk_sync_r[2];
    assign w_cur_s  = ANIM_W[int'(anim_cur_r)*8 +: 8];
    assign h_cur_s  = ANIM_H[int'(anim_cur_r)*8 +: 8];
    assign nf_cur_s = ANIM_NF[int'(anim_cur_r)*4 +: 4];
    assign req_ok_s = anim_req_vld && (int'(anim_req) < NUM_ANIM);
    assign req_os_s = req_ok_s && ONESHOT_PAD[anim_req];
    // A running one-shot can only be interrupted by a different one-shot.
    assign accept_s = tick_s && req_ok_s &&
                      ((state_r == ST_IDLE_LOOP) || (req_os_s && (anim_req != anim_cur_r)));

    // Animation sequencer next state: request acceptance, hold counting, frame advance.
    always_comb begin
        state_nx_s = state_r;
        anim_nx_s  = anim_cur_r;
        frame_nx_s = frame_num_r;
        hold_nx_s  = hold_r;
        done_s     = 1'b0;
        if (accept_s) begin
            anim_nx_s  = anim_req;
            frame_nx_s = 4'd0;
            hold_nx_s  = '0;
            state_nx_s = req_os_s ? ST_ONESHOT : ST_IDLE_LOOP;
        end else if (tick_s && (hold_r == HOLD_W'(FRAME_HOLD - 1))) begin
            hold_nx_s = '0;
            if (frame_num_r == (nf_cur_s - 4'd1)) begin
                frame_nx_s = 4'd0;
                if (state_r == ST_ONESHOT) begin
                    anim_nx_s  = 3'd0;
                    state_nx_s = ST_IDLE_LOOP;
                    done_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE_LOOP;
                end
            end else begin
                frame_nx_s = frame_num_r + 4'd1;
            end
        end else if (tick_s) begin
            hold_nx_s = hold_r + HOLD_W'(1);
        end else begin
            hold_nx_s = hold_r;
        end
    end

    // Motion: knockback or walk, then opponent spacing, then screen clamp.
    always_comb begin
        opp_s    = $signed({2'b00, opp_x});
        x_walk_s = $signed({2'b00, pos_x_r});
        if (accept_s && req_os_s && (anim_req == HURT_IDX)) begin
            if (face_left) begin
                x_walk_s = x_walk_s + KB_S;
            end else begin
                x_walk_s = x_walk_s - KB_S;
            end
        end else if ((state_r == ST_IDLE_LOOP) && (move_left ^ move_right)) begin
            if (move_right) begin
                x_walk_s = x_walk_s + STEP_S;
            end else begin
                x_walk_s = x_walk_s - STEP_S;
            end
        end else begin
            x_walk_s = $signed({2'b00, pos_x_r});
        end
        diff_s = x_walk_s - opp_s;
        if (opp_solid && (diff_s < GAP_S) && (diff_s > -GAP_S)) begin
            if (diff_s >= 12'sd0) begin
                x_gap_s = opp_s + GAP_S;
            end else begin
                x_gap_s = opp_s - GAP_S;
            end
        end else begin
            x_gap_s = x_walk_s;
        end
        if (x_gap_s < XMIN_S) begin
            x_new_s = XMIN_S;
        end else if (x_gap_s > XMAX_S) begin
            x_new_s = XMAX_S;
        end else begin
            x_new_s = x_gap_s;
        end
    end

    // Pixel stage 0: sprite-relative coordinates, hit test and ROM address.
    always_comb begin
        dx_s     = $signed({2'b00, DrawX}) - $signed({2'b00, pos_x_r});
        dy_s     = $signed({2'b00, DrawY}) - $signed({2'b00, pos_y_r});
        w_span_s = {4'b0000, w_cur_s} << SCALE_SH;
        h_span_s = {4'b0000, h_cur_s} << SCALE_SH;
        hit_s    = (dx_s >= 12'sd0) && (dx_s < $signed(w_span_s)) &&
                   (dy_s >= 12'sd0) && (dy_s < $signed(h_span_s));
        col_s    = 8'(dx_s[10:0] >> SCALE_SH);
        row_s    = 8'(dy_s[10:0] >> SCALE_SH);
        if (face_left) begin
            col_m_s = w_cur_s - 8'd1 - col_s;
        end else begin
            col_m_s = col_s;
        end
        addr_s = ANIM_BASE[int'(anim_cur_r)*ADDR_W +: ADDR_W]
               + ADDR_W'(frame_num_r) * ADDR_W'(w_cur_s) * ADDR_W'(h_cur_s)
               + ADDR_W'(row_s) * ADDR_W'(w_cur_s)
               + ADDR_W'(col_m_s);
    end

    // Sequential state: frame_clk sync, animation, position and the pixel pipeline.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fclk_sync_r <= 3'b000;
            state_r     <= ST_IDLE_LOOP;
            anim_cur_r  <= 3'd0;
            frame_num_r <= 4'd0;
            hold_r      <= '0;
            anim_done_r <= 1'b0;
            pos_x_r     <= 10'(START_X);
            pos_y_r     <= 10'(START_Y);
            rom_addr_r  <= '0;
            hit_d1_r    <= 1'b0;
            is_sprite_r <= 1'b0;
            pix_index_r <= 8'h00;
        end else begin
            fclk_sync_r <= {fclk_sync_r[1:0], frame_clk};
            state_r     <= state_nx_s;
            anim_cur_r  <= anim_nx_s;
            frame_num_r <= frame_nx_s;
            hold_r      <= hold_nx_s;
            anim_done_r <= done_s;
            if (tick_s) begin
                pos_x_r <= x_new_s[9:0];
            end
            if (hit_s) begin
                rom_addr_r <= addr_s;
            end
            hit_d1_r    <= hit_s;
            is_sprite_r <= hit_d1_r && (rom_data != TRANSPARENT);
            pix_index_r <= (hit_d1_r && (rom_data != TRANSPARENT)) ? rom_data : 8'h00;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign is_sprite = is_sprite_r;
    assign pix_index = pix_index_r;
    assign pos_x     = pos_x_r;
    assign pos_y     = pos_y_r;
    assign anim_cur  = anim_cur_r;
    assign frame_num = frame_num_r;
    assign anim_done = anim_done_r;

endmodule

// File: tb/tb_fighter_sprite_engine.sv
// Directed bench for fighter_sprite_engine with default parameters; the ROM model
// returns the low address byte, so ROM base 256 maps to the transparent index.
module tb_fighter_sprite_engine;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [2:0]  anim_req = 3'd0;
    logic        anim_req_vld = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        face_left = 1'b0;
    logic [9:0]  opp_x = 10'd0;
    logic        opp_solid = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic        is_sprite;
    logic [7:0]  pix_index;
    logic [9:0]  pos_x, pos_y;
    logic [2:0]  anim_cur;
    logic [3:0]  frame_num;
    logic        anim_done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int d0;

    fighter_sprite_engine dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .anim_req(anim_req), .anim_req_vld(anim_req_vld),
        .move_left(move_left), .move_right(move_right), .face_left(face_left),
        .opp_x(opp_x), .opp_solid(opp_solid), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_data(rom_data), .is_sprite(is_sprite),
        .pix_index(pix_index), .pos_x(pos_x), .pos_y(pos_y),
        .anim_cur(anim_cur), .frame_num(frame_num), .anim_done(anim_done)
    );

    assign rom_data = rom_addr[7:0];

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        if (anim_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (4) @(posedge Clk);
            #1 frame_clk = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
        end
    endtask

    // Present a pixel, check S1 address after one edge and S2 outputs after the next.
    task automatic pixel(input string tag, input int x, input int y, input logic fl,
                         input int exp_addr, input int exp_spr, input int exp_pix);
        DrawX = 10'(x);
        DrawY = 10'(y);
        face_left = fl;
        @(posedge Clk); #1;
        check_val({tag, "_addr"}, int'(rom_addr), exp_addr);
        @(posedge Clk); #1;
        check_val({tag, "_spr"}, int'(is_sprite), exp_spr);
        check_val({tag, "_pix"}, int'(pix_index), exp_pix);
    endtask

    initial begin
        // Reset and idle
        do_reset();
        repeat (10) @(posedge Clk);
        #1;
        check_val("rst_pos_x", int'(pos_x), 560);
        check_val("rst_pos_y", int'(pos_y), 200);
        check_val("rst_anim", int'(anim_cur), 0);
        check_val("rst_frame", int'(frame_num), 0);
        check_val("rst_spr", int'(is_sprite), 0);
        check_val("rst_done", int'(anim_done), 0);

        // Pixel fetch on stand frame 0 at (560,200), W=37 H=60 base 256
        pixel("px_transp", 560, 200, 1'b0, 256, 0, 0);
        pixel("px_opaque", 561, 203, 1'b0, 293, 1, 37);
        pixel("px_mirror", 561, 203, 1'b1, 329, 1, 73);
        pixel("px_miss", 100, 203, 1'b1, 329, 0, 0);
        face_left = 1'b0;

        // Stand loops over two frames, four ticks each
        do_ticks(4);
        check_val("loop_f1", int'(frame_num), 1);
        pixel("px_frame1", 561, 203, 1'b0, 2513, 1, 209);
        do_ticks(4);
        check_val("loop_wrap", int'(frame_num), 0);

        // Walk and clamp at X_MAX
        move_left = 1'b1;
        do_ticks(3);
        check_val("walk_left", int'(pos_x), 557);
        move_left = 1'b0;
        move_right = 1'b1;
        do_ticks(5);
        check_val("walk_clamp", int'(pos_x), 560);
        move_right = 1'b0;

        // Opponent spacing
        move_left = 1'b1;
        do_ticks(208);
        check_val("walk_far", int'(pos_x), 352);
        opp_x = 10'd300;
        opp_solid = 1'b1;
        do_ticks(4);
        check_val("gap_left", int'(pos_x), 350);
        move_left = 1'b0;
        opp_x = 10'd380;
        do_ticks(1);
        check_val("gap_push", int'(pos_x), 330);
        opp_solid = 1'b0;

        // Out-of-range request ignored
        do_reset();
        anim_req = 3'd7;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        check_val("bad_req", int'(anim_cur), 0);

        // One-shot attack plays three frames then returns to stand
        do_reset();
        d0 = done_cnt;
        anim_req = 3'd1;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        check_val("atk_start", int'(anim_cur), 1);
        do_ticks(4);
        check_val("atk_f1", int'(frame_num), 1);
        do_ticks(4);
        check_val("atk_f2", int'(frame_num), 2);
        do_ticks(3);
        check_val("atk_busy", int'(anim_cur), 1);
        check_val("atk_nodone", done_cnt - d0, 0);
        do_ticks(1);
        check_val("atk_done", done_cnt - d0, 1);
        check_val("atk_back", int'(anim_cur), 0);
        check_val("atk_fr0", int'(frame_num), 0);

        // Hurt preempts attack with knockback
        do_reset();
        d0 = done_cnt;
        anim_req = 3'd1;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        do_ticks(4);
        anim_req = 3'd5;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        check_val("hurt_anim", int'(anim_cur), 5);
        check_val("hurt_frame", int'(frame_num), 0);
        check_val("hurt_kb", int'(pos_x), 520);
        check_val("hurt_nodone", done_cnt - d0, 0);
        anim_req = 3'd0;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        check_val("hurt_ignore", int'(anim_cur), 5);
        do_ticks(7);
        check_val("hurt_done", done_cnt - d0, 1);
        check_val("hurt_back", int'(anim_cur), 0);

        // Reset mid-animation aborts silently
        d0 = done_cnt;
        anim_req = 3'd2;
        anim_req_vld = 1'b1;
        do_ticks(1);
        anim_req_vld = 1'b0;
        do_ticks(2);
        do_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_val("abort_anim", int'(anim_cur), 0);
        check_val("abort_nodone", done_cnt - d0, 0);
        check_val("abort_pos", int'(pos_x), 560);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
